// File: rtl/ls243_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ls243_bus_arbiter_pkg
// Purpose  : Shared state encoding, side identifiers and tie-break helper for
//            the sn74ls243 transceiver arbiter.
// Revision : 1.0  initial release
// ============================================================================
package ls243_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_A2B  = 2'd1,
    ST_B2A  = 2'd2,
    ST_TURN = 2'd3
  } arb_state_e;

  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  // Winner among the requesting sides; on a tie the side not served last wins.
  // Result is only meaningful when at least one request is high.
  function automatic logic pick_side(input logic req_a, input logic req_b,
                                     input logic last);
    logic side;
    if (req_a && req_b) begin
      side = ~last;
    end else if (req_a) begin
      side = SIDE_A;
    end else begin
      side = SIDE_B;
    end
    return side;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ls243_arb_timer.sv
`default_nettype none
// ============================================================================
// Module   : ls243_arb_timer
// Purpose  : Dead-time down counter (4 bit) and saturating grant-length
//            counter (8 bit) used by the transceiver arbiter.
// Revision : 1.0  initial release
// ============================================================================
module ls243_arb_timer #(
  parameter int DEAD    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic clk,
  input  logic rst_,
  input  logic load_dead,
  input  logic clr_hold,
  input  logic inc_hold,
  output logic dead_zero,
  output logic hold_hit
);

  localparam logic [3:0] DEAD_LOAD = 4'(DEAD - 1);
  localparam logic [7:0] HOLD_LAST = 8'(MAXHOLD - 1);
  localparam logic       HOLD_EN   = (MAXHOLD != 0);

  logic [3:0] dead_q, dead_d;
  logic [7:0] hold_q, hold_d;

  // Next values: dead counter loads on release and counts down to zero;
  // hold counter clears on grant entry and saturates at its maximum.
  always_comb begin
    dead_d = dead_q;
    hold_d = hold_q;
    if (load_dead) begin
      dead_d = DEAD_LOAD;
    end else if (dead_q != 4'd0) begin
      dead_d = dead_q - 4'd1;
    end
    if (clr_hold) begin
      hold_d = 8'd0;
    end else if (inc_hold && (hold_q != 8'hFF)) begin
      hold_d = hold_q + 8'd1;
    end
  end

  // Counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      dead_q <= 4'd0;
      hold_q <= 8'd0;
    end else begin
      dead_q <= dead_d;
      hold_q <= hold_d;
    end
  end

  assign dead_zero = (dead_q == 4'd0);
  // A zero MAXHOLD disables preemption entirely.
  assign hold_hit  = HOLD_EN && (hold_q == HOLD_LAST);

endmodule
`default_nettype wire

// File: rtl/ls243_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ls243_bus_arbiter
// Purpose  : Shares one sn74ls243 quad transceiver between two requesters
//            with round-robin fairness, bounded grants and dead-time
//            turnaround. ga_=0 together with gb=1 is never produced.
// Revision : 1.0  initial release
// ============================================================================
module ls243_bus_arbiter
  import ls243_bus_arbiter_pkg::*;
#(
  parameter int DEAD    = 1,
  parameter int MAXHOLD = 16
) (
  input  logic clk,
  input  logic rst_,
  input  logic req_a,
  input  logic req_b,
  output logic ga_,
  output logic gb,
  output logic gnt_a,
  output logic gnt_b,
  output logic busy
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       ga_q, ga_d;
  logic       gb_q, gb_d;
  logic       gnt_a_q, gnt_a_d;
  logic       gnt_b_q, gnt_b_d;
  logic       busy_q, busy_d;

  logic       load_dead, clr_hold, inc_hold;
  logic       dead_zero, hold_hit;
  logic       any_req;
  logic       win_side;

  ls243_arb_timer #(
    .DEAD    (DEAD),
    .MAXHOLD (MAXHOLD)
  ) u_timer (
    .clk       (clk),
    .rst_      (rst_),
    .load_dead (load_dead),
    .clr_hold  (clr_hold),
    .inc_hold  (inc_hold),
    .dead_zero (dead_zero),
    .hold_hit  (hold_hit)
  );

  assign any_req  = req_a | req_b;
  assign win_side = pick_side(req_a, req_b, last_q);

  // Next-state logic: arbitrate from IDLE or the final TURN cycle, release a
  // grant on request drop or preemption, and count the turnaround.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    load_dead = 1'b0;
    clr_hold  = 1'b0;
    inc_hold  = 1'b0;
    case (state_q)
      ST_IDLE, ST_TURN: begin
        if ((state_q == ST_IDLE) || dead_zero) begin
          if (any_req) begin
            state_d  = (win_side == SIDE_A) ? ST_A2B : ST_B2A;
            last_d   = win_side;
            clr_hold = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_A2B: begin
        if (!req_a || (hold_hit && req_b)) begin
          state_d   = ST_TURN;
          load_dead = 1'b1;
        end else begin
          inc_hold = 1'b1;
        end
      end
      ST_B2A: begin
        if (!req_b || (hold_hit && req_a)) begin
          state_d   = ST_TURN;
          load_dead = 1'b1;
        end else begin
          inc_hold = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output is its own flop and
  // the enables always agree with the registered state.
  always_comb begin
    ga_d    = (state_d != ST_A2B);
    gb_d    = (state_d == ST_B2A);
    gnt_a_d = (state_d == ST_A2B);
    gnt_b_d = (state_d == ST_B2A);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, last-served flag and output registers; reset drops the enables
  // immediately without any turnaround.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      last_q  <= SIDE_B;
      ga_q    <= 1'b1;
      gb_q    <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      ga_q    <= ga_d;
      gb_q    <= gb_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      busy_q  <= busy_d;
    end
  end

  assign ga_   = ga_q;
  assign gb    = gb_q;
  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ls243_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ls243_bus_arbiter
// Purpose  : Self-checking bench for ls243_bus_arbiter. Two builds run on the
//            same stimulus: u0 (DEAD=2, MAXHOLD=4) and u1 (DEAD=1, MAXHOLD=0).
//            A behavioural owner/gap model predicts every output each cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_ls243_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_;
  logic req_a;
  logic req_b;

  logic ga_w    [2];
  logic gb_w    [2];
  logic gnt_a_w [2];
  logic gnt_b_w [2];
  logic busy_w  [2];

  ls243_bus_arbiter #(.DEAD(2), .MAXHOLD(4)) u_arb0 (
    .clk   (clk),
    .rst_  (rst_),
    .req_a (req_a),
    .req_b (req_b),
    .ga_   (ga_w[0]),
    .gb    (gb_w[0]),
    .gnt_a (gnt_a_w[0]),
    .gnt_b (gnt_b_w[0]),
    .busy  (busy_w[0])
  );

  ls243_bus_arbiter #(.DEAD(1), .MAXHOLD(0)) u_arb1 (
    .clk   (clk),
    .rst_  (rst_),
    .req_a (req_a),
    .req_b (req_b),
    .ga_   (ga_w[1]),
    .gb    (gb_w[1]),
    .gnt_a (gnt_a_w[1]),
    .gnt_b (gnt_b_w[1]),
    .busy  (busy_w[1])
  );

  int p_dead [2] = '{2, 1};
  int p_mh   [2] = '{4, 0};

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 none, 1 A, 2 B.  len: cycles already granted.  gap: disabled
  // turnaround cycles still to come (including the current one).
  int   m_own  [2];
  int   m_len  [2];
  int   m_gap  [2];
  int   m_last [2];
  logic rst_s;

  function automatic int pick(input int last, input logic ra, input logic rb);
    if (ra && rb) return (last == 1) ? 2 : 1;
    if (ra) return 1;
    if (rb) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    rst_s = rst_;
    for (int k = 0; k < 2; k++) begin
      if (!rst_) begin
        m_own[k] = 0; m_len[k] = 0; m_gap[k] = 0; m_last[k] = 2;
      end else if (m_own[k] != 0) begin
        logic mine, other;
        mine  = (m_own[k] == 1) ? req_a : req_b;
        other = (m_own[k] == 1) ? req_b : req_a;
        if (!mine || (p_mh[k] != 0 && m_len[k] == p_mh[k] && other)) begin
          m_own[k] = 0;
          m_gap[k] = p_dead[k];
        end else begin
          m_len[k]++;
        end
      end else if (m_gap[k] > 1) begin
        m_gap[k]--;
      end else begin
        int p;
        m_gap[k] = 0;
        p = pick(m_last[k], req_a, req_b);
        if (p != 0) begin
          m_own[k] = p; m_len[k] = 1; m_last[k] = p;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int obs_off  [2];
  int obs_prev [2];
  bit obs_seen [2];

  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 2; k++) begin
        int cur;
        check($sformatf("u%0d ga_", k),   ga_w[k],    m_own[k] != 1);
        check($sformatf("u%0d gb", k),    gb_w[k],    m_own[k] == 2);
        check($sformatf("u%0d gnt_a", k), gnt_a_w[k], m_own[k] == 1);
        check($sformatf("u%0d gnt_b", k), gnt_b_w[k], m_own[k] == 2);
        check($sformatf("u%0d busy", k),  busy_w[k],  (m_own[k] != 0) || (m_gap[k] != 0));
        check($sformatf("u%0d illegal_enable", k), (!ga_w[k]) && gb_w[k], 1'b0);
        check($sformatf("u%0d grant_overlap", k), gnt_a_w[k] && gnt_b_w[k], 1'b0);
        cur = gnt_a_w[k] ? 1 : (gnt_b_w[k] ? 2 : 0);
        if (!rst_s) begin
          obs_seen[k] = 1'b0; obs_off[k] = 0;
        end else if (cur != 0) begin
          if (obs_seen[k] && (obs_off[k] > 0 || obs_prev[k] != cur))
            check($sformatf("u%0d dead_gap", k), obs_off[k] >= p_dead[k], 1'b1);
          obs_seen[k] = 1'b1; obs_off[k] = 0; obs_prev[k] = cur;
        end else begin
          obs_off[k]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus and literal expectations ----------------
  initial begin
    rst_ = 1'b0; req_a = 1'b1; req_b = 1'b1;
    obs_seen = '{1'b0, 1'b0}; obs_off = '{0, 0}; obs_prev = '{0, 0};
    @(posedge clk); @(negedge clk);
    check_en = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst u%0d ga_", k),   ga_w[k],    1'b1);
      check($sformatf("rst u%0d gb", k),    gb_w[k],    1'b0);
      check($sformatf("rst u%0d gnt_a", k), gnt_a_w[k], 1'b0);
      check($sformatf("rst u%0d gnt_b", k), gnt_b_w[k], 1'b0);
      check($sformatf("rst u%0d busy", k),  busy_w[k],  1'b0);
    end

    // Tie alternation on u0, unlimited hold on u1.
    rst_ = 1'b1;
    for (int i = 0; i < 100; i++) begin
      int pos;
      step();
      pos = i % 12;
      check("tie u0 gnt_a", gnt_a_w[0], pos < 4);
      check("tie u0 gnt_b", gnt_b_w[0], (pos >= 6) && (pos < 10));
      check("hold u1 gnt_a", gnt_a_w[1], 1'b1);
    end

    // u1: A drops, B granted after exactly one dead cycle.
    req_a = 1'b0;
    step();
    check("turn u1 gnt_a", gnt_a_w[1], 1'b0);
    check("turn u1 gnt_b", gnt_b_w[1], 1'b0);
    check("turn u1 busy",  busy_w[1],  1'b1);
    step();
    check("handover u1 gnt_b", gnt_b_w[1], 1'b1);

    // Single A for five cycles on u1.
    rst_ = 1'b0; req_a = 1'b0; req_b = 1'b0;
    step();
    rst_ = 1'b1; req_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("single u1 ga_", ga_w[1], 1'b0);
    end
    req_a = 1'b0;
    step();
    check("single u1 turn ga_",  ga_w[1],   1'b1);
    check("single u1 turn busy", busy_w[1], 1'b1);
    step();
    check("single u1 idle busy", busy_w[1], 1'b0);

    // Reset in the middle of a B grant.
    req_b = 1'b1;
    repeat (3) step();
    check("midrst u1 gb before", gb_w[1], 1'b1);
    rst_ = 1'b0;
    step();
    check("midrst u1 gb",   gb_w[1],   1'b0);
    check("midrst u1 busy", busy_w[1], 1'b0);
    check("midrst u0 gb",   gb_w[0],   1'b0);
    rst_ = 1'b1; req_a = 1'b1;
    step();
    check("midrst u0 tie to A", gnt_a_w[0], 1'b1);
    check("midrst u1 tie to A", gnt_a_w[1], 1'b1);

    // Random stress.
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 4) == 0) req_a = ~req_a;
      if ($urandom_range(0, 4) == 0) req_b = ~req_b;
      rst_ = ($urandom_range(0, 599) != 0);
      step();
    end

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ls243_bus_arbiter.md
Name: ls243_bus_arbiter

Overview:
- Synchronous controller that shares one sn74ls243 quad bus transceiver between two requesters.
  - Side A drives towards B (A->B, ga_ low).
  - Side B drives towards A (B->A, gb high).
- Generates the transceiver enables ga_ and gb, with a guaranteed dead-time turnaround and round-robin fairness.
- Never produces the illegal enable combination ga_=0 with gb=1, which turns both drivers on.
- Sits between bus-master logic and the sn74ls243 instance on a shared bidirectional bus.

Parameters:
- DEAD, 1, turnaround cycles with both directions disabled between grants; legal range 1..15; 4-bit counter.
- MAXHOLD, 16, maximum grant length in cycles while the other side is waiting; legal range 0..255; 0 = unlimited (no preemption); 8-bit counter.

Ports:
- clk    input   1  rising-edge clock.
- rst_   input   1  synchronous reset, active-low.
- req_a  input   1  A side requests to drive A->B.
- req_b  input   1  B side requests to drive B->A.
- ga_    output  1  to sn74ls243 ga_; 0 enables A->B.
- gb     output  1  to sn74ls243 gb; 1 enables B->A.
- gnt_a  output  1  A owns the bus; equals ~ga_.
- gnt_b  output  1  B owns the bus; equals gb.
- busy   output  1  1 in A2B, B2A or TURN.

Behaviour:
- One clock; reset is synchronous and active-low: rst_=0 sampled at a clk rising edge resets the block.
- All outputs are registered and are decoded from the state register only.
- Reset values:
  - state=IDLE, ga_=1, gb=0, gnt_a=0, gnt_b=0, busy=0.
  - last=B, so A wins the first tie.
  - Both counters = 0.
- Reset mid-grant: on the next edge, enables drop straight to disabled and state=IDLE. No turnaround period applies.
- States and enables:
  - IDLE: ga_=1, gb=0.
  - A2B: ga_=0, gb=0.
  - B2A: ga_=1, gb=1.
  - TURN: ga_=1, gb=0.
- Arbitration function, evaluated in IDLE and on the final TURN cycle:
  - req_a only -> A2B.
  - req_b only -> B2A.
  - Both requesting -> the side not equal to last.
  - Neither requesting -> IDLE.
  - On each grant, last <= granted side.
- Grant latency: a request sampled in IDLE at edge N gives the enable active from edge N to N+1, i.e. one cycle.
- A2B / B2A:
  - The hold counter is cleared on entry and incremented each granted cycle, saturating at 255.
  - Release occurs when either:
    - the own request is low, or
    - MAXHOLD!=0, the counter == MAXHOLD-1, and the other request is high (preemption).
  - On release: next state is TURN, and the dead counter is loaded with DEAD-1.
  - Otherwise the state stays put. With no competing request, the grant holds indefinitely.
- TURN:
  - Dead counter != 0: decrement and stay.
  - Dead counter == 0: apply the arbitration function.
  - The disabled window between two grants is therefore exactly DEAD cycles.
  - A request dropped during TURN is simply not granted.
  - A preempted side that still requests loses the tie, because last = itself.
- Simultaneous events:
  - Own request drops in the same cycle that preemption fires: treated as a single release into TURN.
  - Both requests rise in the same cycle in IDLE: resolved by last.
- Invariant: (ga_==0 && gb==1) never occurs, including during reset and X-free startup.

Decomposition:
- Shared include file ls243_arb_defs.v holds:
  - state localparams IDLE=2'd0, A2B=2'd1, B2A=2'd2, TURN=2'd3;
  - SIDE_A=1'b0, SIDE_B=1'b1.
- One sub-module: ls243_arb_timer.
  - Contains the 4-bit dead counter and the 8-bit saturating hold counter.
  - Ports: load_dead, clr_hold, inc_hold, dead_zero, hold_hit.
  - Parameterised by DEAD and MAXHOLD.
- Top level holds the FSM, the last-served flag and output decode.

Test Plan:
- Reset: hold rst_=0 for 2 edges with req_a=req_b=1 -> ga_=1, gb=0, gnt_a=gnt_b=0, busy=0. After release, the first grant goes to A one edge later.
- Single A: req_a=1 for 5 cycles, then 0 (DEAD=1) -> ga_=0 for 5 cycles, then 1 cycle TURN (busy=1), then IDLE with busy=0.
- Tie alternation: req_a=req_b=1 permanently, MAXHOLD=4, DEAD=2 -> grants A(4 cycles), dead(2), B(4), dead(2), A(4)... with gnt_a and gnt_b never overlapping.
- Unlimited hold: MAXHOLD=0, A granted, req_b raised for 100 cycles -> A keeps the bus until req_a drops, then B is granted exactly DEAD cycles later.
- Reset mid-grant: in B2A (gb=1), assert rst_=0 -> at the next edge gb=0 and state=IDLE; the following tie is granted to A.
- Random stress: 10k cycles of random req_a/req_b, random DEAD/MAXHOLD builds, bench drives an sn74ls243 model. Assertions:
  - never ga_=0 with gb=1;
  - the disabled gap between grants is >= DEAD cycles;
  - no bus contention (no X on abus/bbus while a grant is active).
